// File: rtl/logits_topk_pkg.sv
// Shared types and helpers for the top-K logit selector.
package logits_topk_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } topk_state_t;

  // Class-index width: clog2 of the class count, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/logits_topk_insert_slot.sv
// One rank of the sorted insertion list: decides whether the candidate
// belongs at or above this rank and selects the slot's next content.
module logits_topk_insert_slot #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 10
) (
  input  logic [DATA_WIDTH-1:0] new_val,
  input  logic [IDX_W-1:0]      new_idx,
  input  logic                  slot_valid,
  input  logic [DATA_WIDTH-1:0] slot_val,
  input  logic [IDX_W-1:0]      slot_idx,
  input  logic                  prev_win,
  input  logic                  prev_valid,
  input  logic [DATA_WIDTH-1:0] prev_val,
  input  logic [IDX_W-1:0]      prev_idx,
  output logic                  win,
  output logic                  next_valid,
  output logic [DATA_WIDTH-1:0] next_val,
  output logic [IDX_W-1:0]      next_idx
);

  // Strictly greater only: an equal value never displaces, so earlier
  // (lower-index) classes win ties.
  assign win = !slot_valid || ($signed(new_val) > $signed(slot_val));

  // Keep, take the candidate (first winning rank), or shift down from rank r-1.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    next_valid = slot_valid;
    next_val   = slot_val;
    next_idx   = slot_idx;
    if (win) begin
      if (!prev_win) begin
        next_valid = 1'b1;
        next_val   = new_val;
        next_idx   = new_idx;
      end else begin
        next_valid = prev_valid;
        next_val   = prev_val;
        next_idx   = prev_idx;
      end
    end
  end

endmodule

// File: rtl/logits_topk.sv
// Top-K selector: latches a logit vector, scans one class per cycle through
// a registered sorted list, and publishes the K best (index + value).
module logits_topk
  import logits_topk_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CLASSES = 1000,
  parameter int TOP_K       = 5,
  localparam int IDX_W      = idx_width(NUM_CLASSES)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [DATA_WIDTH*NUM_CLASSES-1:0] logits_in,
  output logic                              busy,
  output logic                              done,
  output logic                              out_valid,
  output logic [TOP_K*IDX_W-1:0]            topk_idx,
  output logic [TOP_K*DATA_WIDTH-1:0]       topk_val
);

  if (TOP_K < 1 || TOP_K > NUM_CLASSES) begin : g_bad_top_k
    $error("logits_topk: TOP_K must satisfy 1 <= TOP_K <= NUM_CLASSES");
  end

  localparam logic [IDX_W-1:0] LAST_CLASS = IDX_W'(NUM_CLASSES - 1);

  topk_state_t             state_q, state_d;
  logic [IDX_W-1:0]        class_ctr_q;
  logic                    done_q;
  logic [DATA_WIDTH-1:0]   buf_q [NUM_CLASSES];
  logic [DATA_WIDTH-1:0]   new_val;

  assign new_val   = buf_q[class_ctr_q];
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign out_valid = done_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: idle until start, scan every class once, one publish cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SCAN;
      S_SCAN:  if (class_ctr_q == LAST_CLASS) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Input snapshot so the scan is immune to later changes on logits_in.
  always_ff @(posedge clk) begin
    // NOTE: the logit buffer is not reset; it is always loaded on start before any read.
    if (state_q == S_IDLE && start) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        buf_q[c] <= logits_in[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Class counter and the registered done/out_valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      class_ctr_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      if (state_q == S_IDLE && start) begin
        class_ctr_q <= '0;
      end else if (state_q == S_SCAN && class_ctr_q != LAST_CLASS) begin
        class_ctr_q <= class_ctr_q + 1'b1;
      end
    end
  end

  for (genvar r = 0; r < TOP_K; r++) begin : g_slot
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] val_q;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] out_val_q;
    logic [IDX_W-1:0]      out_idx_q;
    logic                  win;
    logic                  next_valid;
    logic [DATA_WIDTH-1:0] next_val;
    logic [IDX_W-1:0]      next_idx;
    logic                  prev_win;
    logic                  prev_valid;
    logic [DATA_WIDTH-1:0] prev_val;
    logic [IDX_W-1:0]      prev_idx;

    if (r == 0) begin : g_head
      assign prev_win   = 1'b0;
      assign prev_valid = 1'b0;
      assign prev_val   = '0;
      assign prev_idx   = '0;
    end else begin : g_tail
      assign prev_win   = g_slot[r-1].win;
      assign prev_valid = g_slot[r-1].valid_q;
      assign prev_val   = g_slot[r-1].val_q;
      assign prev_idx   = g_slot[r-1].idx_q;
    end

    logits_topk_insert_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_W      (IDX_W)
    ) u_slot (
      .new_val    (new_val),
      .new_idx    (class_ctr_q),
      .slot_valid (valid_q),
      .slot_val   (val_q),
      .slot_idx   (idx_q),
      .prev_win   (prev_win),
      .prev_valid (prev_valid),
      .prev_val   (prev_val),
      .prev_idx   (prev_idx),
      .win        (win),
      .next_valid (next_valid),
      .next_val   (next_val),
      .next_idx   (next_idx)
    );

    // Per-rank list entry: cleared on start, updated while scanning, published in S_DONE.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q   <= 1'b0;
        val_q     <= '0;
        idx_q     <= '0;
        out_val_q <= '0;
        out_idx_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: if (start) valid_q <= 1'b0;
          S_SCAN: begin
            valid_q <= next_valid;
            val_q   <= next_val;
            idx_q   <= next_idx;
          end
          S_DONE: begin
            out_val_q <= val_q;
            out_idx_q <= idx_q;
          end
          default: ;
        endcase
      end
    end

    assign topk_idx[r*IDX_W +: IDX_W]           = out_idx_q;
    assign topk_val[r*DATA_WIDTH +: DATA_WIDTH] = out_val_q;
  end

endmodule

// File: tb/tb_logits_topk.sv
// Bench for logits_topk: directed table on a small instance, multi-cycle
// corner sequences, and random vectors against a sort-based reference.
module tb_logits_topk;

  localparam int SW  = 16;
  localparam int SN  = 8;
  localparam int SK  = 3;
  localparam int SIW = 3;
  localparam int DN  = 1000;
  localparam int DK  = 5;
  localparam int DIW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 s_start = 1'b0;
  logic [SN*SW-1:0]     s_logits = '0;
  logic                 s_busy, s_done, s_valid;
  logic [SK*SIW-1:0]    s_idx;
  logic [SK*SW-1:0]     s_val;

  logic                 d_start = 1'b0;
  logic [DN*SW-1:0]     d_logits = '0;
  logic                 d_busy, d_done, d_valid;
  logic [DK*DIW-1:0]    d_idx;
  logic [DK*SW-1:0]     d_val;

  logits_topk #(.DATA_WIDTH(SW), .NUM_CLASSES(SN), .TOP_K(SK)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .logits_in(s_logits),
    .busy(s_busy), .done(s_done), .out_valid(s_valid),
    .topk_idx(s_idx), .topk_val(s_val)
  );

  logits_topk #(.DATA_WIDTH(SW), .NUM_CLASSES(DN), .TOP_K(DK)) u_big (
    .clk(clk), .rst_n(rst_n), .start(d_start), .logits_in(d_logits),
    .busy(d_busy), .done(d_done), .out_valid(d_valid),
    .topk_idx(d_idx), .topk_val(d_val)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: repeatedly pick the largest unused value, lowest index on ties.
  function automatic void ref_topk(input int v[DN], input int n, input int k,
                                   output int ridx[DK], output int rval[DK]);
    bit used[DN];
    for (int i = 0; i < DN; i++) used[i] = 1'b0;
    for (int r = 0; r < DK; r++) begin
      ridx[r] = 0;
      rval[r] = 0;
    end
    for (int r = 0; r < k; r++) begin
      int best = -1;
      for (int i = 0; i < n; i++) begin
        if (!used[i] && (best < 0 || v[i] > v[best])) best = i;
      end
      used[best] = 1'b1;
      ridx[r] = best;
      rval[r] = v[best];
    end
  endfunction

  // Directed vectors; packed element [0] is class 0 / rank 0.
  typedef struct packed {
    logic [SN-1:0][SW-1:0]  v;
    logic [SK-1:0][SIW-1:0] idx;
    logic [SK-1:0][SW-1:0]  val;
  } vec_t;

  vec_t tbl [4];

  // Pulse start on the small instance and count edges until done.
  task automatic run_small(input logic [SN*SW-1:0] lg, output int lat);
    @(posedge clk); #1;
    s_logits = lg;
    s_start  = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (s_done) break;
    end
  endtask

  task automatic run_big(output int lat);
    @(posedge clk); #1;
    d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
    lat = 0;
    while (lat < 1100) begin
      @(posedge clk); #1;
      lat++;
      if (d_done) break;
    end
  endtask

  task automatic check_small_vec(input string tag, input vec_t t);
    for (int r = 0; r < SK; r++) begin
      check($sformatf("%s idx r%0d", tag, r), longint'(s_idx[r*SIW +: SIW]), longint'(t.idx[r]));
      check($sformatf("%s val r%0d", tag, r), longint'($signed(s_val[r*SW +: SW])),
            longint'($signed(t.val[r])));
    end
  endtask

  initial begin
    int lat;
    int gap;
    int v[DN];
    int ridx[DK];
    int rval[DK];
    vec_t t;

    tbl[0].v   = {16'sd9, 16'sd2, -16'sd5, 16'sd0, 16'sd7, 16'sd7, -16'sd1, 16'sd3};
    tbl[0].idx = {3'd3, 3'd2, 3'd7};
    tbl[0].val = {16'sd7, 16'sd7, 16'sd9};
    tbl[1].v   = {8{16'sd5}};
    tbl[1].idx = {3'd2, 3'd1, 3'd0};
    tbl[1].val = {16'sd5, 16'sd5, 16'sd5};
    tbl[2].v   = {-16'sd7, -16'sd6, -16'sd5, -16'sd4, -16'sd3, -16'sd2, 16'h8000, -16'sd1};
    tbl[2].idx = {3'd3, 3'd2, 3'd0};
    tbl[2].val = {-16'sd3, -16'sd2, -16'sd1};
    tbl[3].v   = {16'sd7, 16'sd6, 16'sd5, 16'sd4, 16'sd3, 16'sd2, 16'sd1, 16'sd0};
    tbl[3].idx = {3'd5, 3'd6, 3'd7};
    tbl[3].val = {16'sd5, 16'sd6, 16'sd7};

    // Reset state.
    #12;
    check("reset busy", longint'(s_busy), 0);
    check("reset done", longint'(s_done), 0);
    check("reset valid", longint'(s_valid), 0);
    check("reset idx", longint'(s_idx), 0);
    check("reset val", longint'(s_val), 0);
    rst_n = 1'b1;

    // Directed table: latency, results, and single-cycle pulses.
    for (int i = 0; i < 4; i++) begin
      run_small(tbl[i].v, lat);
      check($sformatf("t%0d latency", i), longint'(lat), 9);
      check($sformatf("t%0d out_valid", i), longint'(s_valid), 1);
      check_small_vec($sformatf("t%0d", i), tbl[i]);
      @(posedge clk); #1;
      check($sformatf("t%0d done falls", i), longint'(s_done), 0);
      check($sformatf("t%0d valid falls", i), longint'(s_valid), 0);
      check_small_vec($sformatf("t%0d hold", i), tbl[i]);
    end

    // Start re-pulsed mid-scan and input changed: result follows the latched vector.
    @(posedge clk); #1;
    s_logits = tbl[0].v;
    s_start  = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid busy", longint'(s_busy), 1);
    s_start  = 1'b1;
    s_logits = {8{16'sd100}};
    @(posedge clk); #1;
    s_start = 1'b0;
    lat = 4;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (s_done) break;
    end
    check("repulse latency", longint'(lat), 9);
    check_small_vec("repulse", tbl[0]);

    // Start held high: back-to-back scans, done spacing of NUM_CLASSES+2.
    s_start = 1'b1;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (s_done) break;
    end
    check("held first latency", longint'(lat), 10);
    gap = 0;
    while (gap < 40) begin
      @(posedge clk); #1;
      gap++;
      if (s_done) break;
    end
    s_start = 1'b0;
    check("held done gap", longint'(gap), 10);
    t.v   = {8{16'sd100}};
    t.idx = {3'd2, 3'd1, 3'd0};
    t.val = {16'sd100, 16'sd100, 16'sd100};
    check_small_vec("held", t);
    @(posedge clk); #1;
    check("held stops", longint'(s_busy), 0);

    // Asynchronous reset mid-scan, then a clean scan.
    @(posedge clk); #1;
    s_logits = tbl[0].v;
    s_start  = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst busy", longint'(s_busy), 0);
    check("arst done", longint'(s_done), 0);
    check("arst valid", longint'(s_valid), 0);
    check("arst idx", longint'(s_idx), 0);
    check("arst val", longint'(s_val), 0);
    #2;
    rst_n = 1'b1;
    run_small(tbl[2].v, lat);
    check("post-reset latency", longint'(lat), 9);
    check_small_vec("post-reset", tbl[2]);

    // Random vectors on the small instance.
    for (int run = 0; run < 200; run++) begin
      logic [SN*SW-1:0] lg;
      for (int c = 0; c < DN; c++) v[c] = 0;
      for (int c = 0; c < SN; c++) begin
        if (run % 2 == 1) v[c] = int'($urandom_range(0, 6)) - 3;
        else              v[c] = int'($signed(16'($urandom)));
        lg[c*SW +: SW] = 16'(v[c]);
      end
      ref_topk(v, SN, SK, ridx, rval);
      run_small(lg, lat);
      check($sformatf("s%0d latency", run), longint'(lat), 9);
      for (int r = 0; r < SK; r++) begin
        check($sformatf("s%0d idx r%0d", run, r), longint'(s_idx[r*SIW +: SIW]), longint'(ridx[r]));
        check($sformatf("s%0d val r%0d", run, r), longint'($signed(s_val[r*SW +: SW])),
              longint'(rval[r]));
      end
    end

    // Random vectors on the default-size instance.
    for (int run = 0; run < 30; run++) begin
      for (int c = 0; c < DN; c++) begin
        if (run % 2 == 1) v[c] = int'($urandom_range(0, 15)) - 8;
        else              v[c] = int'($signed(16'($urandom)));
        d_logits[c*SW +: SW] = 16'(v[c]);
      end
      ref_topk(v, DN, DK, ridx, rval);
      run_big(lat);
      check($sformatf("d%0d latency", run), longint'(lat), 1001);
      for (int r = 0; r < DK; r++) begin
        check($sformatf("d%0d idx r%0d", run, r), longint'(d_idx[r*DIW +: DIW]), longint'(ridx[r]));
        check($sformatf("d%0d val r%0d", run, r), longint'($signed(d_val[r*SW +: SW])),
              longint'(rval[r]));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
